// File: rtl/rho_lane_sequencer.sv
// Walks the GRIDxGRID lane sequence, rotating each lane in place by its triangular offset.
// Latency: first read 1 cycle after start, first write 3 cycles after; 4 cycles + REDUCE per lane.
// Backpressure: none; lane RAM must return read data exactly one cycle after mem_rd.
module rho_lane_sequencer #(
  parameter int GRID   = 5,
  parameter int LANE_W = 64,
  parameter int ADDR_W = 5,
  parameter int OFF_W  = 7,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [LANE_W-1:0] mem_rdata,
  output logic              mem_wr,
  output logic [LANE_W-1:0] mem_wdata
);

  localparam int XY_W  = (GRID > 2) ? $clog2(GRID) : 1;
  localparam int NY_W  = (GRID > 1) ? $clog2(5*(GRID-1)+1) : 1;
  localparam int STEPS = GRID*GRID-1;

  localparam logic [CNT_W-1:0] LAST_T = CNT_W'(STEPS-1);
  localparam logic [NY_W-1:0]  GRID_N = NY_W'(GRID);
  localparam logic [OFF_W-1:0] LANE_N = OFF_W'(LANE_W);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_WRITE, S_ADVANCE, S_REDUCE, S_DONE
  } state_t;

  state_t            state;
  logic [XY_W-1:0]   x, y;
  logic [NY_W-1:0]   ny_raw;
  logic [OFF_W-1:0]  off_raw, offset;
  logic [CNT_W-1:0]  t;
  logic [LANE_W-1:0] lane_r;
  logic              mode_r;

  logic [2*LANE_W-1:0] lane_dbl;
  logic [OFF_W-1:0]    shamt;

  // Address is a pure function of the current lane coordinates.
  assign mem_addr = ADDR_W'(y) * ADDR_W'(GRID) + ADDR_W'(x);

  // Both directions share one right shifter over the doubled lane: rotate left by k
  // is rotate right by LANE_W-k, and a shift of LANE_W returns the lane unchanged.
  assign lane_dbl  = {lane_r, lane_r};
  assign shamt     = mode_r ? offset : (LANE_N - offset);
  assign mem_wdata = LANE_W'(lane_dbl >> shamt);

  // Sequencer FSM; strobes and handshake outputs are registered alongside the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      x       <= '0;
      y       <= '0;
      t       <= '0;
      ny_raw  <= '0;
      off_raw <= '0;
      offset  <= '0;
      mode_r  <= 1'b0;
      lane_r  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      mem_rd  <= 1'b0;
      mem_wr  <= 1'b0;
    end else begin
      done   <= 1'b0;
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_r <= mode;
            x      <= XY_W'(1);
            y      <= '0;
            t      <= '0;
            offset <= OFF_W'(1);
            busy   <= 1'b1;
            mem_rd <= 1'b1;
            state  <= S_READ;
          end
        end
        S_READ: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          lane_r <= mem_rdata;
          mem_wr <= 1'b1;
          state  <= S_WRITE;
        end
        S_WRITE: begin
          if (t == LAST_T) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_ADVANCE;
          end
        end
        S_ADVANCE: begin
          // Unreduced next y and next offset; the offset grows by t+2 each step.
          x       <= y;
          ny_raw  <= (NY_W'(x) << 1) + NY_W'(y) + (NY_W'(y) << 1);
          off_raw <= offset + OFF_W'(t) + OFF_W'(2);
          t       <= t + CNT_W'(1);
          state   <= S_REDUCE;
        end
        S_REDUCE: begin
          // Iterative modulo by repeated subtraction, both operands in parallel.
          if (ny_raw >= GRID_N || off_raw >= LANE_N) begin
            if (ny_raw >= GRID_N)  ny_raw  <= ny_raw - GRID_N;
            if (off_raw >= LANE_N) off_raw <= off_raw - LANE_N;
          end else begin
            y      <= XY_W'(ny_raw);
            offset <= off_raw;
            mem_rd <= 1'b1;
            state  <= S_READ;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
